// File: rtl/ibuf_mp_pkg.sv
// Shared types and default geometry for the multi-port instruction buffer.
// Optional build macro IBUF_BYPASS_EN (see ibuf_mp.sv) does not change anything here.
package ibuf_mp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  fu_sel;
    logic        pred_taken;
    logic        have_excp;
    logic [4:0]  excp_code;
  } ibuf_entry_t;

  localparam int IBUF_DEPTH      = 8;
  localparam int IBUF_IN_PORTS   = 2;
  localparam int IBUF_OUT_PORTS  = 2;
  localparam int IBUF_READY_FREE = 6;

endpackage

// File: rtl/ibuf_mp_ctrl.sv
// Pointer/occupancy control: clamps push and pop, tracks head/tail/count and sticky overflow.
// Latency: state updates on the edge; IBUF_BYPASS_EN widens the pop window to include incoming slots.
module ibuf_mp_ctrl
  import ibuf_mp_pkg::*;
#(
  parameter int DEPTH      = IBUF_DEPTH,
  parameter int IN_PORTS   = IBUF_IN_PORTS,
  parameter int OUT_PORTS  = IBUF_OUT_PORTS,
  parameter int READY_FREE = IBUF_READY_FREE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [$clog2(IN_PORTS+1)-1:0]    i_size,
  input  logic [$clog2(OUT_PORTS+1)-1:0]   o_size,
  output logic [$clog2(DEPTH)-1:0]         head_q,
  output logic [$clog2(DEPTH)-1:0]         tail_q,
  output logic [$clog2(DEPTH+1)-1:0]       count_q,
  output logic [$clog2(DEPTH+1):0]         avail,
  output logic [$clog2(IN_PORTS+1)-1:0]    wr_lo,
  output logic [$clog2(IN_PORTS+1)-1:0]    wr_hi,
  output logic                             i_ready,
  output logic                             overflow_q
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int WW  = CW + 1;
  localparam int ISW = $clog2(IN_PORTS+1);

  logic [PW-1:0] head_d, tail_d;
  logic [CW-1:0] count_d;
  logic          overflow_d;
  logic [WW-1:0] cnt_w, isz_w, osz_w, pop_w, room_w, push_w, byp_w;

  always_comb begin
    cnt_w = WW'(count_q);
    isz_w = WW'(i_size);
    osz_w = WW'(o_size);
`ifdef IBUF_BYPASS_EN
    avail = cnt_w + isz_w;
`else
    avail = cnt_w;
`endif
    pop_w  = (osz_w < avail) ? osz_w : avail;
    room_w = WW'(DEPTH) - cnt_w + pop_w;
    push_w = (isz_w < room_w) ? isz_w : room_w;
    // Incoming entries popped in the same cycle skip storage entirely.
    byp_w  = (pop_w > cnt_w) ? (pop_w - cnt_w) : '0;

    head_d     = head_q + PW'(pop_w - byp_w);
    tail_d     = tail_q + PW'(push_w - byp_w);
    count_d    = CW'(cnt_w + push_w - pop_w);
    overflow_d = overflow_q | (isz_w > push_w);
    wr_lo      = ISW'(byp_w);
    wr_hi      = ISW'(push_w);

    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = overflow_q;
      wr_lo      = '0;
      wr_hi      = '0;
    end
  end

  assign i_ready = (WW'(DEPTH) - WW'(count_q)) >= WW'(READY_FREE);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/ibuf_mp.sv
// Multi-port in-order instruction buffer: up to IN_PORTS pushes, OUT_PORTS oldest entries shown.
// 1-cycle write-to-read latency; IBUF_BYPASS_EN adds a same-cycle i_data->o_data path. i_ready is advisory.
module ibuf_mp
  import ibuf_mp_pkg::*;
#(
  parameter int WIDTH      = $bits(ibuf_entry_t),
  parameter int DEPTH      = IBUF_DEPTH,
  parameter int IN_PORTS   = IBUF_IN_PORTS,
  parameter int OUT_PORTS  = IBUF_OUT_PORTS,
  parameter int READY_FREE = IBUF_READY_FREE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [$clog2(IN_PORTS+1)-1:0]   i_size,
  input  logic [IN_PORTS*WIDTH-1:0]       i_data,
  output logic                            i_ready,
  input  logic [$clog2(OUT_PORTS+1)-1:0]  o_size,
  output logic [OUT_PORTS-1:0]            o_valid,
  output logic [OUT_PORTS*WIDTH-1:0]      o_data,
  output logic                            o_overflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int ISW = $clog2(IN_PORTS+1);

  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [CW:0]      avail;
  logic [ISW-1:0]   wr_lo, wr_hi;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  ibuf_mp_ctrl #(
    .DEPTH      (DEPTH),
    .IN_PORTS   (IN_PORTS),
    .OUT_PORTS  (OUT_PORTS),
    .READY_FREE (READY_FREE)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .i_size     (i_size),
    .o_size     (o_size),
    .head_q     (head_q),
    .tail_q     (tail_q),
    .count_q    (count_q),
    .avail      (avail),
    .wr_lo      (wr_lo),
    .wr_hi      (wr_hi),
    .i_ready    (i_ready),
    .overflow_q (o_overflow)
  );

  // Slots [wr_lo, wr_hi) land at tail onward; slots below wr_lo were consumed via bypass.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < IN_PORTS; k++) begin
      if (k >= int'(wr_lo) && k < int'(wr_hi)) begin
        mem_d[PW'(int'(tail_q) + k - int'(wr_lo))] = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    o_valid = '0;
    o_data  = '0;
    for (int k = 0; k < OUT_PORTS; k++) begin
      o_valid[k] = int'(avail) > k;
      if (k < int'(count_q)) begin
        o_data[k*WIDTH +: WIDTH] = mem_q[PW'(int'(head_q) + k)];
      end
`ifdef IBUF_BYPASS_EN
      else if (k - int'(count_q) < IN_PORTS) begin
        o_data[k*WIDTH +: WIDTH] = i_data[(k - int'(count_q))*WIDTH +: WIDTH];
      end
`endif
    end
  end

endmodule

// File: tb/tb_ibuf_mp.sv
// Directed bench for ibuf_mp with a queue scoreboard of stored entries.
module tb_ibuf_mp;
  import ibuf_mp_pkg::*;

  localparam int W  = $bits(ibuf_entry_t);
  localparam int D  = 8;
  localparam int IP = 2;
  localparam int OP = 2;
  localparam int RF = 6;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [1:0]      i_size, o_size;
  logic [IP*W-1:0] i_data;
  logic            i_ready;
  logic [OP-1:0]   o_valid;
  logic [OP*W-1:0] o_data;
  logic            o_overflow;

  always #5 clk = ~clk;

  ibuf_mp dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .i_size     (i_size),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_size     (o_size),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_overflow (o_overflow)
  );

  logic [W-1:0] sb[$];
  bit           ovf_m;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_entry();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One cycle: drive, check outputs against the model at negedge, then advance the model.
  task automatic step(input int isz, input int osz, input bit fl);
    logic [W-1:0] inc [IP];
    logic [W-1:0] e;
    int n, avail, pop, push;
    for (int k = 0; k < IP; k++) begin
      inc[k] = rnd_entry();
      i_data[k*W +: W] = inc[k];
    end
    i_size = 2'(isz);
    o_size = 2'(osz);
    flush  = fl;
    @(negedge clk);
    n     = sb.size();
    avail = n + (BYP ? isz : 0);
    for (int k = 0; k < OP; k++) begin
      chk($sformatf("vld%0d", k), 128'(o_valid[k]), 128'(avail > k));
      if (avail > k) begin
        if (k < n) e = sb[k];
        else       e = inc[k-n];
        chk($sformatf("dat%0d", k), 128'(o_data[k*W +: W]), 128'(e));
      end
    end
    chk("i_ready", 128'(i_ready), 128'((D - n) >= RF));
    chk("ovf", 128'(o_overflow), 128'(ovf_m));
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      pop  = (osz < avail) ? osz : avail;
      push = (isz < D - n + pop) ? isz : (D - n + pop);
      if (isz > push) ovf_m = 1'b1;
      for (int k = 0; k < push; k++) sb.push_back(inc[k]);
      for (int k = 0; k < pop; k++) void'(sb.pop_front());
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] vld, input logic rdy, input logic ovf);
    i_size = '0;
    o_size = '0;
    flush  = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"}, 128'(o_valid), 128'(vld));
    chk({tag, "_rdy"}, 128'(i_ready), 128'(rdy));
    chk({tag, "_ovf"}, 128'(o_overflow), 128'(ovf));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    i_size = '0;
    o_size = '0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < D && sb.size() > 0; g++) step(0, 2, 0);
  endtask

  initial begin
    i_data = '0;
    do_reset();
    expect_out("reset", 2'b00, 1'b1, 1'b0);

    // Three double pushes: 6 stored, free space 2 drops i_ready.
    repeat (3) step(2, 0, 0);
    expect_out("fill6", 2'b11, 1'b0, 1'b0);

    // Full buffer streaming through the head wrap.
    step(2, 0, 0);
    repeat (10) step(2, 2, 0);
    expect_out("stream", 2'b11, 1'b0, 1'b0);
    drain();

    // Over-asking pop is clamped; order preserved after a single-entry head move.
    step(1, 0, 0);
    step(0, 2, 0);
    expect_out("clamp", 2'b00, 1'b1, 1'b0);
    step(2, 0, 0);
    step(0, 2, 0);

    // Push beyond free space drops the excess and latches overflow.
    repeat (3) step(2, 0, 0);
    step(1, 0, 0);
    step(2, 0, 0);
    expect_out("ovf", 2'b11, 1'b0, 1'b1);
    drain();
    expect_out("ovf_sticky", 2'b00, 1'b1, 1'b1);

    // Flush overrides a simultaneous push/pop and keeps the overflow flag.
    step(2, 0, 0);
    step(2, 0, 0);
    step(1, 0, 0);
    step(2, 2, 1);
    expect_out("flush", 2'b00, 1'b1, 1'b1);
    do_reset();
    expect_out("rst_clr", 2'b00, 1'b1, 1'b0);

    // Wraparound soak with mixed sizes.
    for (int i = 0; i < 40; i++) step(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    drain();

`ifdef IBUF_BYPASS_EN
    step(2, 1, 0);
    expect_out("byp", 2'b01, 1'b1, ovf_m);
    step(0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
